palindrome_gen: RTL and testbench
=================================

PALINDROME_GEN -- requirements
Module: palindrome_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the output word width (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, a pulse that begins a sweep; honoured only in IDLE.
REQ-005 SHALL have port abort, input, 1, which ends a sweep in progress.
REQ-006 SHALL have port dout, output, DATA_WIDTH, the current palindrome word.
REQ-007 SHALL have port dout_valid, output, 1, meaning dout holds a valid word.
REQ-008 SHALL have port dout_ready, input, 1; the consumer accepts dout when dout_valid and dout_ready are both high.
REQ-009 SHALL have port busy, output, 1, high in RUN.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse after the final word is accepted.

Function
REQ-011 SHALL define H = (DATA_WIDTH+1)/2 and keep an H-bit index k.
REQ-012 SHALL drive dout[DATA_WIDTH-1:DATA_WIDTH-H] = k, and dout[i] = dout[DATA_WIDTH-1-i] for every i < DATA_WIDTH/2.
REQ-013 SHALL, as a result of REQ-012, emit every DATA_WIDTH-bit palindrome exactly once, in strictly ascending numeric order, per sweep.
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE with start=1, move to RUN and clear k to 0; dout_valid goes high on the next cycle, giving 1-cycle latency.
REQ-016 SHALL, in RUN on a handshake with k < 2^H-1, increment k; the next word is valid the following cycle with no bubble.
REQ-017 SHALL, in RUN on a handshake with k = 2^H-1, move to DONE and drop dout_valid, with no wrap-around to 0.
REQ-018 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-019 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-020 SHALL ignore start in RUN and DONE; start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-021 SHALL, on abort in RUN, return to IDLE the next cycle without asserting done; abort takes priority over a same-cycle handshake, which counts as not accepted.
REQ-022 SHALL drive dout to 0 whenever dout_valid=0.

Reset
REQ-023 SHALL, while resetn=0, force state to IDLE, k=0, dout=0, dout_valid=0, busy=0, done=0, and count=0 when count is present.
REQ-024 SHALL treat a reset during RUN as an abort: no done pulse, and a new start is required.

Configuration
REQ-025 SHALL, with PALGEN_COUNT_EN defined, add output port count of width H+1 that clears on start and increments on each accepted word.
REQ-026 SHALL, with PALGEN_COUNT_EN defined, hold count at 2^H when done pulses.
REQ-027 SHALL, without PALGEN_COUNT_EN, omit the count port and its register entirely, with all other behaviour unchanged.

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/DONE) and a constant function computing H from package palgen_pkg.
REQ-029 SHALL place the pure combinational k-to-dout mirror of REQ-012 in sub-module pal_mirror (parameter DATA_WIDTH).

Verification
REQ-030 SHALL check: DATA_WIDTH=5, start, dout_ready=1 held -> dout sequence 0,4,10,14,17,21,27,31; done pulses one cycle after 31 is accepted; busy then drops.
REQ-031 SHALL check: DATA_WIDTH=5, dout_ready toggled randomly -> same 8 words, no duplicates or drops, dout stable while stalled.
REQ-032 SHALL check: DATA_WIDTH=1 -> words 0,1, then done; with PALGEN_COUNT_EN, count=2.
REQ-033 SHALL check: DATA_WIDTH=32, abort after 3 accepted words (0x00000000, 0x00018000, 0x00024000) -> IDLE, no done; a fresh start restarts at 0.
REQ-034 SHALL check: resetn pulled low mid-sweep asynchronously -> all outputs 0 immediately; start ignored while RUN.
REQ-035 SHALL check: every emitted word -> passes an independent bit-mirror palindrome check.

Source files
------------

// File: rtl/palgen_pkg.sv
// Shared types and helpers for the palindrome sweep generator.
package palgen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } palgen_state_e;

   // Number of free (upper) bits that define a palindrome of width w.
   function automatic int half_width(input int w);
      return (w + 32'sd1) / 32'sd2;
   endfunction

endpackage

// File: rtl/palindrome_gen_if.sv
// Control and streaming handshake bundle for palindrome_gen.
// Optional count port present when PALGEN_COUNT_EN is defined.
interface palindrome_gen_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  abort;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  busy;
   logic                  done;
`ifdef PALGEN_COUNT_EN
   logic [(DATA_WIDTH+1)/2:0] count;

   modport master (input start, abort, dout_ready,
                   output dout, dout_valid, busy, done, count);
   modport slave  (output start, abort, dout_ready,
                   input dout, dout_valid, busy, done, count);
`else
   modport master (input start, abort, dout_ready,
                   output dout, dout_valid, busy, done);
   modport slave  (output start, abort, dout_ready,
                   input dout, dout_valid, busy, done);
`endif
endinterface

// File: rtl/pal_mirror.sv
// Combinational index-to-palindrome mapping: k fills the upper half,
// the lower bits mirror the upper bits.
module pal_mirror
   import palgen_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   localparam int H          = half_width(DATA_WIDTH)
) (
   input  logic [H-1:0]          k,
   output logic [DATA_WIDTH-1:0] word
);

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      if (i >= DATA_WIDTH - H) begin : g_top
         assign word[i] = k[i - (DATA_WIDTH - H)];
      end else begin : g_low
         // word[i] = word[DATA_WIDTH-1-i], which lands on k[H-1-i]
         assign word[i] = k[H - 1 - i];
      end
   end

endmodule

// File: rtl/palindrome_gen.sv
// Sweeps every DATA_WIDTH-bit palindrome in ascending order over a valid/ready stream.
// Optional feature macro: PALGEN_COUNT_EN adds an accepted-word counter port.
module palindrome_gen
   import palgen_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input logic              clk,
   input logic              resetn,
   palindrome_gen_if.master bus
);

   localparam int H = half_width(DATA_WIDTH);
   localparam logic [H-1:0] K_MAX = {H{1'b1}};

   palgen_state_e         state_r;
   logic [H-1:0]          k_r;
   logic [H-1:0]          k_inc_s;
   logic [DATA_WIDTH-1:0] mirror_s;
   logic [DATA_WIDTH-1:0] dout_r;
   logic                  dout_valid_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  hs_s;
`ifdef PALGEN_COUNT_EN
   logic [H:0]            count_r;
`endif

   // The word registered on a handshake is the mirror of the next index.
   assign k_inc_s = k_r + H'(1'b1);
   assign hs_s    = dout_valid_r & bus.dout_ready;

   pal_mirror #(.DATA_WIDTH(DATA_WIDTH)) u_mirror (
      .k    (k_inc_s),
      .word (mirror_s)
   );

   // Sweep control FSM with registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IDLE;
         k_r          <= {H{1'b0}};
         dout_r       <= {DATA_WIDTH{1'b0}};
         dout_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
`ifdef PALGEN_COUNT_EN
         count_r      <= {(H+1){1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start && !bus.abort) begin
                  state_r      <= RUN;
                  k_r          <= {H{1'b0}};
                  dout_r       <= {DATA_WIDTH{1'b0}};
                  dout_valid_r <= 1'b1;
                  busy_r       <= 1'b1;
`ifdef PALGEN_COUNT_EN
                  count_r      <= {(H+1){1'b0}};
`endif
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state_r      <= IDLE;
                  dout_r       <= {DATA_WIDTH{1'b0}};
                  dout_valid_r <= 1'b0;
                  busy_r       <= 1'b0;
               end else if (hs_s) begin
`ifdef PALGEN_COUNT_EN
                  count_r <= count_r + (H+1)'(1'b1);
`endif
                  if (k_r == K_MAX) begin
                     // Last palindrome taken: stop rather than wrap to zero.
                     state_r      <= DONE;
                     dout_r       <= {DATA_WIDTH{1'b0}};
                     dout_valid_r <= 1'b0;
                     busy_r       <= 1'b0;
                     done_r       <= 1'b1;
                  end else begin
                     k_r    <= k_inc_s;
                     dout_r <= mirror_s;
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r      <= IDLE;
               k_r          <= {H{1'b0}};
               dout_r       <= {DATA_WIDTH{1'b0}};
               dout_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               done_r       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
`ifdef PALGEN_COUNT_EN
   assign bus.count      = count_r;
`endif

endmodule

// File: tb/tb_palindrome_gen.sv
// Directed self-checking bench for palindrome_gen at widths 5, 1 and 32.
module tb_palindrome_gen;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   palindrome_gen_if #(.DATA_WIDTH(5))  if5 ();
   palindrome_gen_if #(.DATA_WIDTH(1))  if1 ();
   palindrome_gen_if #(.DATA_WIDTH(32)) if32 ();

   palindrome_gen #(.DATA_WIDTH(5))  dut5  (.clk(clk), .resetn(resetn), .bus(if5));
   palindrome_gen #(.DATA_WIDTH(1))  dut1  (.clk(clk), .resetn(resetn), .bus(if1));
   palindrome_gen #(.DATA_WIDTH(32)) dut32 (.clk(clk), .resetn(resetn), .bus(if32));

   always #5 clk = ~clk;

   logic [4:0] exp5 [8];
   initial begin
      exp5[0] = 5'd0;  exp5[1] = 5'd4;  exp5[2] = 5'd10; exp5[3] = 5'd14;
      exp5[4] = 5'd17; exp5[5] = 5'd21; exp5[6] = 5'd27; exp5[7] = 5'd31;
   end

   // Independent model: reverse the low w bits of v.
   function automatic logic [31:0] rev_bits(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({if5.dout, if5.dout_valid, if5.busy, if5.done} !== 8'd0) begin
         errors++;
         $display("FAIL reset5 got %0h want 0", {if5.dout, if5.dout_valid, if5.busy, if5.done});
      end
      checks++;
      if ({if32.dout, if32.dout_valid, if32.busy, if32.done} !== 35'd0) begin
         errors++;
         $display("FAIL reset32 got %0h want 0", {if32.dout, if32.dout_valid, if32.busy, if32.done});
      end
      checks++;
      if ({if1.dout, if1.dout_valid, if1.busy, if1.done} !== 4'd0) begin
         errors++;
         $display("FAIL reset1 got %0h want 0", {if1.dout, if1.dout_valid, if1.busy, if1.done});
      end
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_start_abort_idle();
      if5.start = 1'b1;
      if5.abort = 1'b1;
      tick();
      if5.start = 1'b0;
      if5.abort = 1'b0;
      checks++;
      if (if5.busy !== 1'b0 || if5.dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_abort_idle got busy=%b valid=%b want 0 0", if5.busy, if5.dout_valid);
      end
      tick();
   endtask

   task automatic test_sweep5();
      if5.dout_ready = 1'b1;
      if5.start = 1'b1;
      tick();
      if5.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (if5.dout_valid !== 1'b1 || if5.dout !== exp5[i] || if5.busy !== 1'b1) begin
            errors++;
            $display("FAIL sweep5[%0d] got v=%b d=%0d b=%b want 1 %0d 1", i, if5.dout_valid, if5.dout, if5.busy, exp5[i]);
         end
         checks++;
         if (rev_bits({27'd0, if5.dout}, 5) !== {27'd0, if5.dout}) begin
            errors++;
            $display("FAIL pal5[%0d] got %0d not a palindrome", i, if5.dout);
         end
         tick();
      end
      checks++;
      if (if5.done !== 1'b1 || if5.dout_valid !== 1'b0 || if5.busy !== 1'b0 || if5.dout !== 5'd0) begin
         errors++;
         $display("FAIL done5 got d=%b v=%b b=%b o=%0d want 1 0 0 0", if5.done, if5.dout_valid, if5.busy, if5.dout);
      end
`ifdef PALGEN_COUNT_EN
      checks++;
      if (if5.count !== 4'd8) begin
         errors++;
         $display("FAIL count5 got %0d want 8", if5.count);
      end
`endif
      tick();
      checks++;
      if (if5.done !== 1'b0 || if5.busy !== 1'b0) begin
         errors++;
         $display("FAIL done5_pulse got done=%b busy=%b want 0 0", if5.done, if5.busy);
      end
      if5.dout_ready = 1'b0;
   endtask

   task automatic test_stall5();
      logic [31:0] pat;
      logic        rdy;
      int          idx;
      int          n;
      pat = 32'hB34D_2C91;
      if5.start = 1'b1;
      tick();
      if5.start = 1'b0;
      idx = 0;
      n   = 0;
      while (idx < 8 && n < 100) begin
         rdy = pat[n % 32];
         if5.dout_ready = rdy;
         checks++;
         if (if5.dout_valid !== 1'b1 || if5.dout !== exp5[idx]) begin
            errors++;
            $display("FAIL stall5 cyc%0d got v=%b d=%0d want 1 %0d", n, if5.dout_valid, if5.dout, exp5[idx]);
         end
         tick();
         n++;
         if (rdy) idx++;
      end
      if5.dout_ready = 1'b0;
      checks++;
      if (idx !== 8 || if5.done !== 1'b1) begin
         errors++;
         $display("FAIL stall5_end got words=%0d done=%b want 8 1", idx, if5.done);
      end
      tick();
   endtask

   task automatic test_width1();
      if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      checks++;
      if (if1.dout_valid !== 1'b1 || if1.dout !== 1'b0) begin
         errors++;
         $display("FAIL w1_first got v=%b d=%b want 1 0", if1.dout_valid, if1.dout);
      end
      if1.dout_ready = 1'b1;
      tick();
      checks++;
      if (if1.dout_valid !== 1'b1 || if1.dout !== 1'b1) begin
         errors++;
         $display("FAIL w1_second got v=%b d=%b want 1 1", if1.dout_valid, if1.dout);
      end
      tick();
      if1.dout_ready = 1'b0;
      checks++;
      if (if1.done !== 1'b1 || if1.dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL w1_done got done=%b v=%b want 1 0", if1.done, if1.dout_valid);
      end
`ifdef PALGEN_COUNT_EN
      checks++;
      if (if1.count !== 2'd2) begin
         errors++;
         $display("FAIL w1_count got %0d want 2", if1.count);
      end
`endif
      tick();
   endtask

   task automatic test_abort32();
      logic [31:0] exp32 [4];
      exp32[0] = 32'h0000_0000;
      exp32[1] = 32'h0001_8000;
      exp32[2] = 32'h0002_4000;
      exp32[3] = 32'h0003_C000;
      if32.dout_ready = 1'b1;
      if32.start = 1'b1;
      tick();
      if32.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (if32.dout_valid !== 1'b1 || if32.dout !== exp32[i]) begin
            errors++;
            $display("FAIL abort32_w%0d got v=%b d=%h want 1 %h", i, if32.dout_valid, if32.dout, exp32[i]);
         end
         checks++;
         if (rev_bits(if32.dout, 32) !== if32.dout) begin
            errors++;
            $display("FAIL pal32[%0d] got %h not a palindrome", i, if32.dout);
         end
         if (i < 3) tick();
      end
      if32.abort = 1'b1;
      tick();
      if32.abort = 1'b0;
      checks++;
      if (if32.dout_valid !== 1'b0 || if32.busy !== 1'b0 || if32.done !== 1'b0 || if32.dout !== 32'd0) begin
         errors++;
         $display("FAIL abort32 got v=%b b=%b dn=%b d=%h want 0 0 0 0", if32.dout_valid, if32.busy, if32.done, if32.dout);
      end
      tick();
      checks++;
      if (if32.done !== 1'b0 || if32.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort32_nodone got done=%b busy=%b want 0 0", if32.done, if32.busy);
      end
      if32.start = 1'b1;
      tick();
      if32.start = 1'b0;
      checks++;
      if (if32.dout_valid !== 1'b1 || if32.dout !== 32'd0) begin
         errors++;
         $display("FAIL restart32 got v=%b d=%h want 1 0", if32.dout_valid, if32.dout);
      end
      tick();
      checks++;
      if (if32.dout !== 32'h0001_8000) begin
         errors++;
         $display("FAIL restart32_w1 got %h want 00018000", if32.dout);
      end
   endtask

   task automatic test_reset_midsweep();
      if32.start = 1'b1;
      tick();
      if32.start = 1'b0;
      checks++;
      if (if32.dout !== 32'h0002_4000 || if32.busy !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run got d=%h b=%b want 00024000 1", if32.dout, if32.busy);
      end
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++;
      if ({if32.dout, if32.dout_valid, if32.busy, if32.done} !== 35'd0) begin
         errors++;
         $display("FAIL async_reset got %h want 0", {if32.dout, if32.dout_valid, if32.busy, if32.done});
      end
`ifdef PALGEN_COUNT_EN
      checks++;
      if (if32.count !== 17'd0) begin
         errors++;
         $display("FAIL async_reset_count got %0d want 0", if32.count);
      end
`endif
      tick();
      resetn = 1'b1;
      tick();
      tick();
      checks++;
      if (if32.dout_valid !== 1'b0 || if32.busy !== 1'b0 || if32.done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got v=%b b=%b d=%b want 0 0 0", if32.dout_valid, if32.busy, if32.done);
      end
      if32.dout_ready = 1'b0;
   endtask

   initial begin
      clk    = 1'b0;
      resetn = 1'b0;
      checks = 0;
      errors = 0;
      if5.start = 1'b0;  if5.abort = 1'b0;  if5.dout_ready = 1'b0;
      if1.start = 1'b0;  if1.abort = 1'b0;  if1.dout_ready = 1'b0;
      if32.start = 1'b0; if32.abort = 1'b0; if32.dout_ready = 1'b0;
      test_reset();
      test_start_abort_idle();
      test_sweep5();
      test_stall5();
      test_width1();
      test_abort32();
      test_reset_midsweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
